// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constant derivations for the RAM burst reader.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // RAM read latency: an output register on the RAM adds one cycle.
  function automatic int read_latency(input string is_out_latency);
    return (is_out_latency == "true") ? 2 : 1;
  endfunction

  // Two slots beyond the read latency keep the stream running with no bubbles.
  function automatic int buffer_depth(input int lat);
    return lat + 2;
  endfunction

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Small synchronous show-ahead FIFO; the head entry is visible while not empty.
module ram_stream_reader_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Qualify requests: no pop when empty, no push when full unless a pop frees a slot.
  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: issues sequential RAM reads under a credit limit, captures the
// returning words into a show-ahead buffer and presents them as a stream.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int    DATA_WIDTH     = 8,
  parameter int    ADDR_WIDTH     = 8,
  parameter string IS_OUT_LATENCY = "false"
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH-1:0] length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i
);

  localparam int LAT   = read_latency(IS_OUT_LATENCY);
  localparam int DEPTH = buffer_depth(LAT);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int FW    = DATA_WIDTH + 1;

  state_t                state_q;
  logic                  busy_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   left_q;      // reads still to issue; 2^ADDR_WIDTH fits
  logic [LAT-1:0]        cap_vld_q, cap_vld_d;
  logic [LAT-1:0]        cap_last_q, cap_last_d;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [FW-1:0]         fifo_head;
  logic                  pop, issue, last_issue;
  int                    inflight;

  // Credit check: a read may issue only if buffer plus in-flight reads stay
  // within DEPTH; a pop this cycle counts as a freed slot. rd_en is decided
  // combinationally so that freed slot is usable in the same cycle.
  always_comb begin
    pop      = !fifo_empty && m_ready_i;
    inflight = 0;
    for (int i = 0; i < LAT; i++) inflight += int'(cap_vld_q[i]);
    issue      = (state_q == ISSUE) && ((int'(fifo_cnt) + inflight) < (DEPTH + int'(pop)));
    last_issue = issue && (left_q == (ADDR_WIDTH + 1)'(1));
  end

  // Capture tracker: a read issued now returns LAT cycles later.
  always_comb begin
    cap_vld_d     = '0;
    cap_last_d    = '0;
    cap_vld_d[0]  = issue;
    cap_last_d[0] = last_issue;
    for (int i = 1; i < LAT; i++) begin
      cap_vld_d[i]  = cap_vld_q[i-1];
      cap_last_d[i] = cap_last_q[i-1];
    end
  end

  // Shift the tracker; reset drops reads in flight so they never reach the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_vld_q  <= '0;
      cap_last_q <= '0;
    end else begin
      cap_vld_q  <= cap_vld_d;
      cap_last_q <= cap_last_d;
    end
  end

  ram_stream_reader_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cap_vld_q[LAT-1]),
    .data_i  ({cap_last_q[LAT-1], rd_data_i}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Burst control FSM with registered busy/done. A start arriving while done
  // pulses is dropped so back-to-back bursts are separated by one idle cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      left_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !done_q) begin
            addr_q  <= start_addr_i;
            left_q  <= {1'b0, length_i} + (ADDR_WIDTH + 1)'(1);
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q <= addr_q + 1'b1;
            left_q <= left_q - 1'b1;
            if (last_issue) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && fifo_head[DATA_WIDTH]) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = issue;
  assign rd_addr_o = addr_q;
  assign m_valid_o = !fifo_empty;
  assign m_data_o  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
  assign m_last_o  = !fifo_empty && fifo_head[DATA_WIDTH];

endmodule
